// File: rtl/arm_pkg.sv
// arm_pkg: types and constants shared by the ARM memory-stage blocks.
//   sram_state_t   : controller FSM states (IDLE, LOW, HIGH, DONE)
//   SRAM_BASE_ADDR : pipeline byte address mapped to SRAM half-word 0
//   SRAM_DW        : SRAM data bus width
package arm_pkg;

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} sram_state_t;

    localparam logic [31:0] SRAM_BASE_ADDR = 32'd1024;
    localparam int SRAM_DW = 16;

endpackage

// File: rtl/sram_io_buf.sv
// sram_io_buf: tri-state driver for the bidirectional SRAM data bus.
//   en   in   drive dout onto dq when high, release dq otherwise
//   dout in   data to drive
//   din  out  current bus value
//   dq   inout SRAM data bus
module sram_io_buf
    import arm_pkg::*;
(
    input  logic               en,
    input  logic [SRAM_DW-1:0] dout,
    output logic [SRAM_DW-1:0] din,
    inout  wire  [SRAM_DW-1:0] dq
);

    assign dq  = en ? dout : {SRAM_DW{1'bz}};
    assign din = dq;

endmodule

// File: rtl/sram_mem_ctrl.sv
// sram_mem_ctrl: performs a 32-bit pipeline load/store as two half-word
// accesses on a 16-bit asynchronous SRAM, holding ready low to freeze the pipe.
//   clk, rst    clock; asynchronous active-low reset
//   rd_en/wr_en load/store request (sampled in IDLE only; write wins)
//   address     byte address, write_data store data
//   read_data   registered load result, ready low means freeze
//   sram_addr, sram_dq, sram_we_n, sram_oe_n  SRAM pins
module sram_mem_ctrl
    import arm_pkg::*;
#(
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = SRAM_BASE_ADDR,
    parameter int          SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    inout  wire  [SRAM_DW-1:0] sram_dq,
    output logic               sram_we_n,
    output logic               sram_oe_n
);

    sram_state_t state, next_state;
    logic [3:0] phase;
    logic is_wr, req, last, busy, drive;
    logic [31:0] wdata, off;
    logic [SRAM_DW-1:0] dout, din;
    logic unused;

    assign off  = address - BASE_ADDR;
    assign req  = rd_en | wr_en;
    assign last = phase == 4'(WAIT_CYCLES);
    assign busy = (state == LOW) | (state == HIGH);
    assign dout = (state == HIGH) ? wdata[31:16] : wdata[15:0];
    // byte-lane bits and bits beyond the SRAM window are dropped on purpose
    assign unused = ^{off[31:SRAM_AW+1], off[1:0]};

    always_comb begin
        next_state = state;
        case (state)
            IDLE: next_state = req ? LOW : IDLE;
            LOW:  next_state = last ? HIGH : LOW;
            HIGH: next_state = last ? DONE : HIGH;
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
        ready     = (state == DONE) | ((state == IDLE) & ~req);
        drive     = busy & is_wr;
        sram_we_n = ~(busy & is_wr);
        sram_oe_n = ~(busy & ~is_wr);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            phase     <= 4'd0;
            is_wr     <= 1'b0;
            wdata     <= 32'd0;
            read_data <= 32'd0;
            sram_addr <= '0;
        end else begin
            state <= next_state;
            phase <= (busy && !last) ? phase + 4'd1 : 4'd0;
            if (state == IDLE && req) begin
                is_wr     <= wr_en;
                wdata     <= write_data;
                sram_addr <= {off[SRAM_AW:2], 1'b0};
            end
            // the low half is always the even half-word, so the high half only sets bit 0
            if (state == LOW && last) begin
                sram_addr[0] <= 1'b1;
                if (!is_wr) read_data[15:0] <= din;
            end
            if (state == HIGH && last && !is_wr) read_data[31:16] <= din;
        end
    end

    sram_io_buf u_buf (
        .en  (drive),
        .dout(dout),
        .din (din),
        .dq  (sram_dq)
    );

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// tb_sram_mem_ctrl: directed, table-driven check of sram_mem_ctrl with an SRAM model.
module tb_sram_mem_ctrl;
    import arm_pkg::*;

    logic clk = 1'b0, rst = 1'b0, rd_en = 1'b0, wr_en = 1'b0;
    logic [31:0] address = 32'd0, write_data = 32'd0;
    logic [31:0] read_data;
    logic ready, sram_we_n, sram_oe_n;
    logic [17:0] sram_addr;
    wire  [15:0] sram_dq;

    sram_mem_ctrl #(.WAIT_CYCLES(1), .BASE_ADDR(32'd1024), .SRAM_AW(18)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en),
        .address(address), .write_data(write_data), .read_data(read_data),
        .ready(ready), .sram_addr(sram_addr), .sram_dq(sram_dq),
        .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:255];
    assign sram_dq = !sram_oe_n ? mem[sram_addr[7:0]] : 16'bz;
    always @(posedge clk) if (!sram_we_n) mem[sram_addr[7:0]] <= sram_dq;

    typedef struct {
        logic rd, wr;
        logic [31:0] addr, wdata;
        logic rdy, we_n, oe_n;
        logic [17:0] saddr;
        logic chk_dq;
        logic [15:0] dq;
        logic [31:0] rdata;
    } vec_t;

    vec_t tbl [14];
    int vectors = 0, miscompares = 0;

    function automatic vec_t v(logic rd, logic wr, logic [31:0] a, logic [31:0] d,
                               logic rdy, logic we, logic oe, logic [17:0] sa,
                               logic cd, logic [15:0] dq, logic [31:0] rdt);
        vec_t r;
        r.rd = rd; r.wr = wr; r.addr = a; r.wdata = d;
        r.rdy = rdy; r.we_n = we; r.oe_n = oe; r.saddr = sa;
        r.chk_dq = cd; r.dq = dq; r.rdata = rdt;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (ready !== 1'b1 && n < 20) begin
            @(negedge clk); #2;
            n++;
        end
        check(name, 64'(ready), 64'd1);
    endtask

    logic [11:0] rdy_seq;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0;
        // store 0xDEADBEEF to 1032 (half-words 4/5), then load it back
        tbl[0]  = v(0, 1, 32'd1032, 32'hDEADBEEF, 0, 1, 1, 18'd0, 0, 16'h0,    32'h0);
        tbl[1]  = v(0, 0, 32'd0,    32'h0,        0, 0, 1, 18'd4, 1, 16'hBEEF, 32'h0);
        tbl[2]  = v(0, 0, 32'd0,    32'h0,        0, 0, 1, 18'd4, 1, 16'hBEEF, 32'h0);
        tbl[3]  = v(0, 0, 32'd0,    32'h0,        0, 0, 1, 18'd5, 1, 16'hDEAD, 32'h0);
        tbl[4]  = v(0, 0, 32'd0,    32'h0,        0, 0, 1, 18'd5, 1, 16'hDEAD, 32'h0);
        tbl[5]  = v(0, 0, 32'd0,    32'h0,        1, 1, 1, 18'd5, 0, 16'h0,    32'h0);
        tbl[6]  = v(0, 0, 32'd0,    32'h0,        1, 1, 1, 18'd5, 0, 16'h0,    32'h0);
        tbl[7]  = v(1, 0, 32'd1032, 32'h0,        0, 1, 1, 18'd5, 0, 16'h0,    32'h0);
        tbl[8]  = v(0, 0, 32'd0,    32'h0,        0, 1, 0, 18'd4, 1, 16'hBEEF, 32'h0);
        tbl[9]  = v(0, 0, 32'd0,    32'h0,        0, 1, 0, 18'd4, 1, 16'hBEEF, 32'h0);
        tbl[10] = v(0, 0, 32'd0,    32'h0,        0, 1, 0, 18'd5, 1, 16'hDEAD, 32'h0000BEEF);
        tbl[11] = v(0, 0, 32'd0,    32'h0,        0, 1, 0, 18'd5, 1, 16'hDEAD, 32'h0000BEEF);
        tbl[12] = v(0, 0, 32'd0,    32'h0,        1, 1, 1, 18'd5, 0, 16'h0,    32'hDEADBEEF);
        tbl[13] = v(0, 0, 32'd0,    32'h0,        1, 1, 1, 18'd5, 0, 16'h0,    32'hDEADBEEF);

        // reset state while rst is held low
        #2;
        check("reset ready", 64'(ready), 64'd1);
        check("reset we_n/oe_n", 64'({sram_we_n, sram_oe_n}), 64'd3);
        check("reset read_data", 64'(read_data), 64'd0);
        check("reset sram_addr", 64'(sram_addr), 64'd0);
        check("reset dq drive", 64'(dut.u_buf.en), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 14; i++) begin
            rd_en = tbl[i].rd; wr_en = tbl[i].wr;
            address = tbl[i].addr; write_data = tbl[i].wdata;
            #2;
            check($sformatf("row %0d rdy/we/oe/addr/rdata", i),
                  {11'd0, ready, sram_we_n, sram_oe_n, sram_addr, read_data},
                  {11'd0, tbl[i].rdy, tbl[i].we_n, tbl[i].oe_n, tbl[i].saddr, tbl[i].rdata});
            if (tbl[i].chk_dq) check($sformatf("row %0d dq", i), 64'(sram_dq), 64'(tbl[i].dq));
            @(negedge clk);
        end
        check("store hw4/hw5", 64'({mem[5], mem[4]}), 64'hDEADBEEF);

        // back-to-back stores with the request held throughout
        wr_en = 1'b1; address = 32'd1024; write_data = 32'h11112222;
        for (int c = 0; c < 12; c++) begin
            #2;
            rdy_seq[c] = ready;
            @(negedge clk);
            if (c == 0) begin address = 32'd1028; write_data = 32'h33334444; end
        end
        wr_en = 1'b0;
        check("b2b ready pattern", 64'(rdy_seq), 64'(12'b1000_0010_0000));
        check("b2b hw0-3", {mem[3], mem[2], mem[1], mem[0]}, 64'h3333_4444_1111_2222);
        check("b2b read_data kept", 64'(read_data), 64'hDEADBEEF);

        // illegal rd+wr decode: write wins
        @(negedge clk);
        rd_en = 1'b1; wr_en = 1'b1; address = 32'd1040; write_data = 32'h12345678;
        #2;
        check("dual req ready", 64'(ready), 64'd0);
        @(negedge clk);
        rd_en = 1'b0; wr_en = 1'b0;
        #2;
        check("dual req we_n/oe_n", 64'({sram_we_n, sram_oe_n}), 64'd1);
        wait_ready("dual req done");
        check("dual req hw8/hw9", 64'({mem[9], mem[8]}), 64'h12345678);
        check("dual req read_data kept", 64'(read_data), 64'hDEADBEEF);

        // reset during the HIGH phase of a load
        @(negedge clk);
        rd_en = 1'b1; address = 32'd1032;
        @(negedge clk);
        rd_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        check("high phase oe_n/addr", 64'({sram_oe_n, sram_addr}), 64'({1'b0, 18'd5}));
        rst = 1'b0;
        #1;
        check("abort ready", 64'(ready), 64'd1);
        check("abort we_n/oe_n", 64'({sram_we_n, sram_oe_n}), 64'd3);
        check("abort dq drive", 64'(dut.u_buf.en), 64'd0);
        check("abort read_data", 64'(read_data), 64'd0);
        check("abort sram_addr", 64'(sram_addr), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        rd_en = 1'b1; address = 32'd1040;
        #2;
        check("post-reset req ready", 64'(ready), 64'd0);
        @(negedge clk);
        rd_en = 1'b0;
        #2;
        wait_ready("post-reset load done");
        check("post-reset load data", 64'(read_data), 64'h12345678);
        @(negedge clk);
        #2;
        check("post-reset data held", 64'(read_data), 64'h12345678);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
